// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the internal-bus transfer sequencer: bus code map,
// counter sizing and the sequencer state type.
package bus_xfer_pkg;

  localparam int CODE_W      = 5;
  localparam int NUM_BUS_SRC = 24;
  localparam int CNT_W       = 3;  // holds SETTLE_CYCLES-1 for SETTLE_CYCLES up to 8

  localparam logic [CODE_W-1:0] CODE_R0     = 5'd0;
  localparam logic [CODE_W-1:0] CODE_R1     = 5'd1;
  localparam logic [CODE_W-1:0] CODE_R2     = 5'd2;
  localparam logic [CODE_W-1:0] CODE_R3     = 5'd3;
  localparam logic [CODE_W-1:0] CODE_R4     = 5'd4;
  localparam logic [CODE_W-1:0] CODE_R5     = 5'd5;
  localparam logic [CODE_W-1:0] CODE_R6     = 5'd6;
  localparam logic [CODE_W-1:0] CODE_R7     = 5'd7;
  localparam logic [CODE_W-1:0] CODE_R8     = 5'd8;
  localparam logic [CODE_W-1:0] CODE_R9     = 5'd9;
  localparam logic [CODE_W-1:0] CODE_R10    = 5'd10;
  localparam logic [CODE_W-1:0] CODE_R11    = 5'd11;
  localparam logic [CODE_W-1:0] CODE_R12    = 5'd12;
  localparam logic [CODE_W-1:0] CODE_R13    = 5'd13;
  localparam logic [CODE_W-1:0] CODE_R14    = 5'd14;
  localparam logic [CODE_W-1:0] CODE_R15    = 5'd15;
  localparam logic [CODE_W-1:0] CODE_HI     = 5'd16;
  localparam logic [CODE_W-1:0] CODE_LO     = 5'd17;
  localparam logic [CODE_W-1:0] CODE_ZHI    = 5'd18;
  localparam logic [CODE_W-1:0] CODE_ZLO    = 5'd19;
  localparam logic [CODE_W-1:0] CODE_PC     = 5'd20;
  localparam logic [CODE_W-1:0] CODE_MDR    = 5'd21;
  localparam logic [CODE_W-1:0] CODE_INPORT = 5'd22;
  localparam logic [CODE_W-1:0] CODE_C      = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_LATCH,
    ST_DONE
  } xfer_state_e;

endpackage

// File: rtl/onehot_decode5.sv
// 5-bit bus code to 24-bit one-hot enable decoder; codes 24-31 give all-zero
// enables and a low valid flag.
module onehot_decode5
  import bus_xfer_pkg::*;
(
  input  logic [CODE_W-1:0]      code,
  output logic [NUM_BUS_SRC-1:0] onehot,
  output logic                   valid
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    onehot = '0;
    valid  = (code < CODE_W'(NUM_BUS_SRC));
    if (valid) onehot[code] = 1'b1;
  end

endmodule

// File: rtl/bus_xfer_decoder.sv
// Register-to-register move sequencer: drives the source onto the bus for
// SETTLE_CYCLES+1 cycles, pulses the destination load, then reports done.
// Optional invalid-code abort is enabled by defining BUS_XFER_ERR_EN.
module bus_xfer_decoder
  import bus_xfer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   start,
  input  logic [CODE_W-1:0]      src_code,
  input  logic [CODE_W-1:0]      dst_code,
  output logic [NUM_BUS_SRC-1:0] src_out,
  output logic [NUM_BUS_SRC-1:0] dst_in,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  xfer_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CODE_W-1:0]      src_code_q, src_code_d;
  logic [CODE_W-1:0]      dst_code_q, dst_code_d;
  logic [NUM_BUS_SRC-1:0] src_out_q, src_out_d;
  logic [NUM_BUS_SRC-1:0] dst_in_q, dst_in_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_BUS_SRC-1:0] src_dec, dst_dec;
  logic                   src_valid, dst_valid;
  logic                   accept;

  assign accept = (state_q == ST_IDLE) && start;

  // Decoding the next-value of the code registers lets the source enable be
  // registered at the sampling edge itself.
  assign src_code_d = accept ? src_code : src_code_q;
  assign dst_code_d = accept ? dst_code : dst_code_q;

  onehot_decode5 u_src_dec (
    .code   (src_code_d),
    .onehot (src_dec),
    .valid  (src_valid)
  );

  onehot_decode5 u_dst_dec (
    .code   (dst_code_d),
    .onehot (dst_dec),
    .valid  (dst_valid)
  );

`ifdef BUS_XFER_ERR_EN
  logic err_q, err_d;
`else
  logic unused_valid;
  assign unused_valid = src_valid ^ dst_valid;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_out_d = src_out_q;
    dst_in_d  = '0;
    done_d    = 1'b0;
`ifdef BUS_XFER_ERR_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        src_out_d = '0;
        if (start) begin
`ifdef BUS_XFER_ERR_EN
          if (!(src_valid && dst_valid)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else
`endif
          begin
            state_d   = ST_DRIVE;
            cnt_d     = SETTLE_LOAD;
            src_out_d = src_dec;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d  = ST_LATCH;
          dst_in_d = dst_dec;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LATCH: begin
        state_d   = ST_DONE;
        src_out_d = '0;
        done_d    = 1'b1;
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        src_out_d = '0;
      end
      default: begin
        state_d   = ST_IDLE;
        src_out_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      src_code_q <= '0;
      dst_code_q <= '0;
      src_out_q  <= '0;
      dst_in_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BUS_XFER_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_code_q <= src_code_d;
      dst_code_q <= dst_code_d;
      src_out_q  <= src_out_d;
      dst_in_q   <= dst_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef BUS_XFER_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  assign src_out = src_out_q;
  assign dst_in  = dst_in_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef BUS_XFER_ERR_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule
